mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 134 +++++++++++++
 tb/tb_mdu_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide unit with HI/LO registers
// Shift-add multiply and restoring divide on magnitudes; sign fix-up on the way out.

module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] w_q;
    logic [31:0] m_q;
    logic [31:0] a_q;
    logic        div_q;
    logic        sa_q;
    logic        sb_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        sgn_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic [31:0] div_sub;
    logic        div_ge;
    logic [63:0] w_d;
    logic [63:0] prod;
    logic [31:0] res_hi_d;
    logic [31:0] res_lo_d;

    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & a[31];
        b_neg  = sgn_op & b[31];
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;

        // Multiply: w = {partial product, remaining multiplier bits}.
        // Divide:   w = {partial remainder, dividend bits / quotient bits}.
        mul_sum = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, m_q} : 33'd0);
        div_rem = w_q[63:31];
        div_ge  = (div_rem >= {1'b0, m_q});
        div_sub = div_rem[31:0] - m_q;
        if (div_q) begin
            w_d = div_ge ? {div_sub, w_q[30:0], 1'b1} : {w_q[62:0], 1'b0};
        end else begin
            w_d = {mul_sum, w_q[31:1]};
        end

        prod = (sa_q ^ sb_q) ? (64'd0 - w_q) : w_q;
        if (!div_q) begin
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
        end else if (m_q == 32'd0) begin
            res_hi_d = a_q;
            res_lo_d = 32'hFFFF_FFFF;
        end else begin
            res_hi_d = sa_q ? (32'd0 - w_q[63:32]) : w_q[63:32];
            res_lo_d = (sa_q ^ sb_q) ? (32'd0 - w_q[31:0]) : w_q[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            w_q     <= 64'd0;
            m_q     <= 32'd0;
            a_q     <= 32'd0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !op[2]) begin
                        div_q   <= op[1];
                        sa_q    <= a_neg;
                        sb_q    <= b_neg;
                        a_q     <= a;
                        m_q     <= op[1] ? b_mag : a_mag;
                        w_q     <= {32'd0, op[1] ? a_mag : b_mag};
                        cnt_q   <= 6'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else if (start && op[2:1] == 2'b10) begin
                        if (op[0]) lo_q <= a;
                        else       hi_q <= a;
                        done_q <= 1'b1;
                    end
                end
                RUN: begin
                    w_q   <= w_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= FIN;
                end
                FIN: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl
// Stimulus pushes expected {hi,lo,done cycle}; a negedge monitor pops on done.

module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   nvec  = 0;
    int   nerr  = 0;

    mdu_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest expectation, at the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("hi", {32'd0, hi}, {32'd0, e.hi});
                    check("lo", {32'd0, lo}, {32'd0, e.lo});
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                check("missing_done", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one op at a negedge; scramble inputs after E0. For iterative ops measure
    // busy length and optionally poke a second start (MTHI) n cycles into the run.
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo, input int poke);
        exp_t e;
        int   n;
        start = 1'b1; op = o; a = av; b = bv;
        e.hi = ehi; e.lo = elo;
        e.cyc = cyc + 1 + (o[2] ? 0 : 33);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; op = 3'b100; a = ~av; b = ~bv;
        if (o[2]) begin
            check("mt_busy", {63'd0, busy}, 64'd0);
        end else begin
            n = 0;
            while (busy === 1'b1 && n < 100) begin
                n++;
                if (n == poke) begin
                    start = 1'b1; op = 3'b100; a = 32'd55; b = 32'd9;
                end else if (n == poke + 1) begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check("busy_len", 64'(n), 64'd33);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        do_op(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        do_op(3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, 0);
        do_op(3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op(3'b011, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 0);
        do_op(3'b010, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 0);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        do_op(3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0);
        do_op(3'b100, 32'hDEAD_BEEF, 32'd3,        32'hDEAD_BEEF, 32'hFFFF_FFFD, 0);
        do_op(3'b101, 32'h0000_CAFE, 32'd3,        32'hDEAD_BEEF, 32'h0000_CAFE, 0);
        do_op(3'b011, 32'd100,       32'd7,        32'd2,         32'd14,        5);

        // Reserved op: no done, registers unchanged.
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 32'h5555_5555; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rsv_busy", {63'd0, busy}, 64'd0);
        check("rsv_hilo", {hi, lo}, {32'd2, 32'd14});

        // Back-to-back: second start lands in the first op's done cycle.
        do_op(3'b001, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0,         0);
        do_op(3'b001, 32'h1234_5678, 32'd9,         32'd0, 32'hA3D7_0A38, 0);

        // Reset mid-operation aborts without done or partial result.
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd1000; b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        do_op(3'b101, 32'h0000_1234, 32'd0, 32'd0, 32'h0000_1234, 0);

        repeat (40) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
